// File: rtl/uart_receptor_pkg.sv
// Shared constants for the UART command receiver.
// FSM state codes and handler opcodes.
package uart_receptor_pkg;

  localparam logic [2:0] OCIOSO   = 3'd0;
  localparam logic [2:0] INICIO   = 3'd1;
  localparam logic [2:0] DADOS    = 3'd2;
  localparam logic [2:0] PARADA   = 3'd3;
  localparam logic [2:0] RECUPERA = 3'd4;

  localparam logic [3:0] NOP      = 4'd0;
  localparam logic [3:0] LIMPAR   = 4'd1;
  localparam logic [3:0] CARREGAR = 4'd2;
  localparam logic [3:0] MOSTRAR  = 4'd4;

endpackage

// File: rtl/uart_receptor_sincronizador.sv
// Two-flop synchronizer for the async rx line, resets to idle-high.
// Ports: clock, reset_n (sync, active-low), i_d async in, o_q synced out.
module uart_receptor_sincronizador (
  input  logic clock,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/uart_receptor.sv
// 8N1 UART receiver splitting each byte into a command strobe and data.
// Ports: clock, reset_n (sync, active-low), rx serial in;
//   instrucao (timed strobe), dado (held), valido, erro_quadro, ocupado.
module uart_receptor
  import uart_receptor_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int BAUD     = 9600,
  parameter int CMD_HOLD = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx,
  output logic [3:0] instrucao,
  output logic [3:0] dado,
  output logic       valido,
  output logic       erro_quadro,
  output logic       ocupado
);

  localparam int CPB = CLK_HZ / BAUD;
  localparam int BW  = $clog2(CPB);
  localparam int HW  = $clog2(CMD_HOLD + 1);

  localparam logic [BW-1:0] HALF = BW'(CPB / 2 - 1);
  localparam logic [BW-1:0] LAST = BW'(CPB - 1);
  localparam logic [HW-1:0] HOLD = HW'(CMD_HOLD);
  localparam logic [HW-1:0] ONE  = HW'(1);

  logic          w_rxs;
  logic [2:0]    r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_byte;
  logic [HW-1:0] r_hold;
  logic [3:0]    r_instr;
  logic [3:0]    r_dado;
  logic          r_valido;
  logic          r_erro;

  uart_receptor_sincronizador u_sinc (
    .clock   (clock),
    .reset_n (reset_n),
    .i_d     (rx),
    .o_q     (w_rxs)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state  <= OCIOSO;
      r_baud   <= '0;
      r_bit    <= '0;
      r_byte   <= '0;
      r_hold   <= '0;
      r_instr  <= '0;
      r_dado   <= '0;
      r_valido <= 1'b0;
      r_erro   <= 1'b0;
    end else begin
      r_valido <= 1'b0;
      r_erro   <= 1'b0;
      // strobe expiry; a good frame below overrides it
      if (r_hold != '0) begin
        r_hold <= r_hold - ONE;
        if (r_hold == ONE)
          r_instr <= NOP;
      end
      case (r_state)
        OCIOSO: begin
          if (!w_rxs) begin
            r_state <= INICIO;
            r_baud  <= '0;
          end
        end
        INICIO: begin
          if (r_baud == HALF) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_state <= w_rxs ? OCIOSO : DADOS;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        DADOS: begin
          if (r_baud == LAST) begin
            r_baud        <= '0;
            r_byte[r_bit] <= w_rxs;
            if (r_bit == 3'd7) begin
              r_bit   <= '0;
              r_state <= PARADA;
            end else begin
              r_bit <= r_bit + 3'd1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        PARADA: begin
          if (r_baud == LAST) begin
            r_baud <= '0;
            if (w_rxs) begin
              r_valido <= 1'b1;
              r_instr  <= r_byte[7:4];
              r_dado   <= r_byte[3:0];
              r_hold   <= HOLD;
              r_state  <= OCIOSO;
            end else begin
              r_erro  <= 1'b1;
              r_state <= RECUPERA;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        RECUPERA: begin
          // a held-low line must go idle before a new start is accepted
          if (w_rxs)
            r_state <= OCIOSO;
        end
        default: r_state <= OCIOSO;
      endcase
    end
  end

  assign instrucao   = r_instr;
  assign dado        = r_dado;
  assign valido      = r_valido;
  assign erro_quadro = r_erro;
  assign ocupado     = (r_state != OCIOSO);

endmodule

// File: tb/tb_uart_receptor.sv
// Randomized self-checking bench for uart_receptor.
// Reference: byte queue, frame start times and event counters.
module tb_uart_receptor;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic [3:0] instrucao;
  logic [3:0] dado;
  logic       valido;
  logic       erro_quadro;
  logic       ocupado;

  uart_receptor #(
    .CLK_HZ   (16),
    .BAUD     (1),
    .CMD_HOLD (4)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rx          (rx),
    .instrucao   (instrucao),
    .dado        (dado),
    .valido      (valido),
    .erro_quadro (erro_quadro),
    .ocupado     (ocupado)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] exp_q[$];
  int         t0_q[$];
  int         exp_fe = 0;
  int         n_good = 0;
  int         n_val = 0;
  int         n_fe = 0;
  logic [3:0] mdl_dado = 4'h0;
  bit         mon_on = 1'b0;

  logic [7:0] m_b;
  int         m_t;
  int         m_lat;
  bit         run_on = 1'b0;
  logic [3:0] run_hi;
  int         run_n;

  always @(negedge clock) begin
    if (mon_on) begin
      if (valido) begin
        n_val++;
        if (exp_q.size() == 0) begin
          chk("valido_unexpected", 1, 0);
        end else begin
          m_b = exp_q.pop_front();
          m_t = t0_q.pop_front();
          m_lat = cyc - m_t;
          chk("dado", {28'd0, dado}, {28'd0, m_b[3:0]});
          chk("instrucao", {28'd0, instrucao}, {28'd0, m_b[7:4]});
          chk("latency", (m_lat >= 154 && m_lat <= 156) ? 155 : m_lat, 155);
          mdl_dado = m_b[3:0];
          run_hi = m_b[7:4];
          run_n = 1;
          run_on = (m_b[7:4] != 4'h0);
        end
      end else if (run_on) begin
        if (instrucao == run_hi) begin
          run_n++;
        end else begin
          chk("hold_len", run_n, 4);
          chk("hold_zero", {28'd0, instrucao}, 0);
          run_on = 1'b0;
        end
      end
      if (erro_quadro) begin
        n_fe++;
        chk("err_dado", {28'd0, dado}, {28'd0, mdl_dado});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    @(negedge clock);
    rx = 1'b0;
    if (stop) begin
      exp_q.push_back(b);
      t0_q.push_back(cyc);
      n_good++;
    end else begin
      exp_fe++;
    end
    repeat (16) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(negedge clock);
    end
    rx = stop;
    repeat (16) @(negedge clock);
    rx = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  int  v0;
  int  e0;
  bit  seen;
  logic [7:0] rb;
  logic       rs;

  initial begin
    reset_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_instrucao", {28'd0, instrucao}, 0);
    chk("rst_dado", {28'd0, dado}, 0);
    chk("rst_valido", {31'd0, valido}, 0);
    chk("rst_erro", {31'd0, erro_quadro}, 0);
    chk("rst_ocupado", {31'd0, ocupado}, 0);
    reset_n = 1'b1;
    mon_on = 1'b1;
    idle(5);

    v0 = n_val;
    send(8'h2A, 1'b1);
    idle(30);
    chk("t1_valido_cnt", n_val - v0, 1);
    chk("t1_dado", {28'd0, dado}, 32'hA);
    chk("t1_instr_idle", {28'd0, instrucao}, 0);

    v0 = n_val;
    e0 = n_fe;
    send(8'h4F, 1'b0);
    idle(30);
    chk("t2_erro_cnt", n_fe - e0, 1);
    chk("t2_no_valido", n_val - v0, 0);
    chk("t2_dado_kept", {28'd0, dado}, 32'hA);
    chk("t2_instr_kept", {28'd0, instrucao}, 0);
    send(8'h13, 1'b1);
    idle(30);
    chk("t2_dado_new", {28'd0, dado}, 32'h3);

    v0 = n_val;
    e0 = n_fe;
    @(negedge clock);
    rx = 1'b0;
    repeat (3) @(negedge clock);
    rx = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (ocupado) seen = 1'b1;
    end
    chk("t3_busy_seen", {31'd0, seen}, 1);
    chk("t3_idle", {31'd0, ocupado}, 0);
    chk("t3_no_valido", n_val - v0, 0);
    chk("t3_no_erro", n_fe - e0, 0);

    v0 = n_val;
    send(8'h1F, 1'b1);
    send(8'h40, 1'b1);
    idle(30);
    chk("t4_valido_cnt", n_val - v0, 2);
    chk("t4_dado", {28'd0, dado}, 0);

    @(negedge clock);
    rx = 1'b0;
    repeat (40) @(negedge clock);
    chk("t5_busy", {31'd0, ocupado}, 1);
    rx = 1'b1;
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    chk("t5_instrucao", {28'd0, instrucao}, 0);
    chk("t5_dado", {28'd0, dado}, 0);
    chk("t5_valido", {31'd0, valido}, 0);
    chk("t5_erro", {31'd0, erro_quadro}, 0);
    chk("t5_ocupado", {31'd0, ocupado}, 0);
    mdl_dado = 4'h0;
    idle(20);
    send(8'h25, 1'b1);
    idle(30);
    chk("t5_dado_after", {28'd0, dado}, 32'h5);

    v0 = n_val;
    e0 = n_fe;
    @(negedge clock);
    rx = 1'b0;
    exp_fe++;
    repeat (640) @(negedge clock);
    chk("t6_erro_once", n_fe - e0, 1);
    chk("t6_recupera", {31'd0, ocupado}, 1);
    rx = 1'b1;
    idle(10);
    chk("t6_idle", {31'd0, ocupado}, 0);
    chk("t6_erro_final", n_fe - e0, 1);
    chk("t6_no_valido", n_val - v0, 0);

    for (int k = 0; k < 24; k++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 4) != 0);
      send(rb, rs);
      if (!rs) idle(20);
      else idle($urandom_range(0, 3));
    end
    idle(40);

    chk("end_queue_empty", exp_q.size(), 0);
    chk("end_valido_total", n_val, n_good);
    chk("end_erro_total", n_fe, exp_fe);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
